// File: rtl/nios_pio_pkg.sv
// Shared register offsets and edge-type encodings for the switch/button input PIO.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and debounced state with a change pulse.
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic prime_done,
    input  logic din,
    output logic dout,
    output logic change
);

    logic sync_p0;
    logic sync_p1;

    // Stage boundary: asynchronous pin into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout <= 1'b0;
                end else begin
                    dout <= sync_p1;
                end
            end

            assign change = prime_done & (dout ^ sync_p1);
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // Stage boundary: synchronised bit into the debounced state.
            // While priming, state tracks sync silently so a held input never looks like an edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout   <= 1'b0;
                    cnt    <= '0;
                    change <= 1'b0;
                end else if (!prime_done) begin
                    dout   <= sync_p1;
                    cnt    <= '0;
                    change <= 1'b0;
                end else if (sync_p1 == dout) begin
                    cnt    <= '0;
                    change <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    dout   <= sync_p1;
                    cnt    <= '0;
                    change <= 1'b1;
                end else begin
                    cnt    <= cnt + 1'b1;
                    change <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/nios_project_switch_pio.sv
// Avalon-MM input PIO: debounced switch inputs, per-bit edge capture and a maskable level IRQ.
module nios_project_switch_pio
    import nios_pio_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = EDGE_ANY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [1:0]       prime_cnt;
    logic             prime_done;
    logic [WIDTH-1:0] data_val;
    logic [WIDTH-1:0] change;
    logic [WIDTH-1:0] new_val;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_wdata;

    assign prime_done   = (prime_cnt == 2'd3);
    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= 2'd0;
        end else if (!prime_done) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk        (clk),
            .reset      (reset),
            .prime_done (prime_done),
            .din        (in_port[i]),
            .dout       (data_val[i]),
            .change     (change[i])
        );
    end

    // In bypass the change flag is combinational, so the new level is the synchronised bit.
    always_comb begin
        new_val = (DEBOUNCE_CYCLES == 0) ? (data_val ^ change) : data_val;
        case (EDGE_TYPE)
            EDGE_RISING:  edge_evt = change & new_val;
            EDGE_FALLING: edge_evt = change & ~new_val;
            default:      edge_evt = change;
        endcase
    end

    always_comb begin
        cap_clr = '0;
        if (wr_en && address == ADDR_EDGE) begin
            cap_clr = writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = data_val;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
            default:   rd_mux = '0;
        endcase
    end

    // Stage boundary: bus-visible registers and the interrupt flop.
    // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
            irq      <= |(edge_cap & irq_mask);
            if (chipselect) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_nios_project_switch_pio.sv
// Bench for the input PIO with a short debounce window and rising-edge capture.
module tb_nios_project_switch_pio;
    import nios_pio_pkg::*;

    localparam int WIDTH = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  in_port;
    logic              irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [9:0] in_val;
        logic [9:0] data;
        logic [9:0] cap;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    nios_project_switch_pio #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (EDGE_RISING)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        exp_q.push_back(exp);
        @(negedge clk);
        chipselect = 1'b0;
        check(name, readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic        irq_seen;
        logic [31:0] v;

        vecs[0] = '{in_val: 10'h3FF, data: 10'h3FF, cap: 10'h38A};
        vecs[1] = '{in_val: 10'h2AA, data: 10'h2AA, cap: 10'h000};
        vecs[2] = '{in_val: 10'h155, data: 10'h155, cap: 10'h155};
        vecs[3] = '{in_val: 10'h000, data: 10'h000, cap: 10'h000};
        vecs[4] = '{in_val: 10'h200, data: 10'h200, cap: 10'h200};

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 10'h3FF;

        // Reset with all inputs held high: priming must absorb them silently.
        idle(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        irq_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            irq_seen |= irq;
        end
        check("t1_irq_held", {31'b0, irq_seen}, 32'h0);
        rd(ADDR_DATA, 32'h3FF, "t1_data");
        rd(ADDR_EDGE, 32'h0, "t1_cap");
        rd(ADDR_MASK, 32'h0, "t1_mask");

        // Falling edges are ignored in rising mode.
        in_port = 10'h000;
        idle(12);
        rd(ADDR_DATA, 32'h0, "fall_data");
        rd(ADDR_EDGE, 32'h0, "fall_cap");

        // Rising edge on bit 0: exact capture and irq latency.
        wr(ADDR_MASK, 32'h001);
        @(negedge clk);
        in_port    = 10'h001;
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = ADDR_EDGE;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back((k >= 7) ? 32'h1 : 32'h0);
            @(negedge clk);
            v = exp_q.pop_front();
            check($sformatf("t2_cap_e%0d", k), readdata, v);
            check($sformatf("t2_irq_e%0d", k), {31'b0, irq}, v);
        end
        chipselect = 1'b0;
        wr(ADDR_EDGE, 32'h001);
        check("t2_irq_at_clear", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("t2_irq_after_clear", {31'b0, irq}, 32'h0);
        rd(ADDR_EDGE, 32'h0, "t2_cap_cleared");

        // Three-cycle glitch on bit 3 must be rejected.
        @(negedge clk);
        in_port = 10'h009;
        idle(3);
        in_port = 10'h001;
        idle(10);
        rd(ADDR_DATA, 32'h001, "t3_data");
        rd(ADDR_EDGE, 32'h0, "t3_cap");

        // W1C in the same cycle bit 2 captures: the edge wins.
        @(negedge clk);
        in_port = 10'h005;
        idle(6);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_EDGE;
        writedata  = 32'h004;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(ADDR_EDGE, 32'h004, "t4_cap_edge_wins");
        wr(ADDR_EDGE, 32'h004);
        rd(ADDR_EDGE, 32'h0, "t4_cap_cleared");

        // Masking, zero-bit writes and the reserved word.
        wr(ADDR_MASK, 32'h0);
        @(negedge clk);
        in_port = 10'h035;
        idle(12);
        check("t5_irq_masked", {31'b0, irq}, 32'h0);
        rd(ADDR_EDGE, 32'h030, "t5_cap");
        wr(ADDR_EDGE, 32'h0);
        rd(ADDR_EDGE, 32'h030, "t5_cap_w0");
        wr(ADDR_MASK, 32'h010);
        check("t5_irq_same", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("t5_irq_next", {31'b0, irq}, 32'h1);
        rd(ADDR_RSVD, 32'h0, "t5_rsvd");
        rd(ADDR_MASK, 32'h010, "t5_mask");
        wr(ADDR_RSVD, 32'hFFFF_FFFF);
        rd(ADDR_RSVD, 32'h0, "t5_rsvd_wr");
        rd(ADDR_MASK, 32'h010, "t5_mask_after_rsvd");

        // Reset while bit 6 is two counts into its debounce window.
        @(negedge clk);
        in_port = 10'h075;
        idle(4);
        reset = 1'b1;
        @(negedge clk);
        check("t6_readdata_rst", readdata, 32'h0);
        check("t6_irq_rst", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        idle(15);
        check("t6_irq_after", {31'b0, irq}, 32'h0);
        rd(ADDR_DATA, 32'h075, "t6_data");
        rd(ADDR_EDGE, 32'h0, "t6_cap");
        rd(ADDR_MASK, 32'h0, "t6_mask");

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_port = vecs[i].in_val;
            idle(12);
            rd(ADDR_DATA, {22'b0, vecs[i].data}, $sformatf("vec%0d_data", i));
            rd(ADDR_EDGE, {22'b0, vecs[i].cap}, $sformatf("vec%0d_cap", i));
            wr(ADDR_EDGE, 32'h3FF);
        end

        // A pulse exactly one debounce window long is accepted both ways.
        @(negedge clk);
        in_port = 10'h202;
        idle(4);
        in_port = 10'h200;
        idle(12);
        rd(ADDR_DATA, 32'h200, "pulse4_data");
        rd(ADDR_EDGE, 32'h002, "pulse4_cap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
